// File: rtl/spi_pkg.sv
// Shared SPI definitions: transfer FSM states and the default word width
// used by both the APB register slice and the shift engine.
package spi_pkg;

  // Default bits per transfer; the APB slice sizes its data registers from this.
  localparam int unsigned SpiDataWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// Byte-level SPI transfer engine. Accepts a parallel word, holds slave select
// low for the transfer, shifts MOSI out and MISO in on the baud generator's
// strobes, and returns the received word with a one-cycle valid pulse.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SpiDataWidth
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  lsbfe,
  output logic                  tx_ready,
  input  logic                  flags_low,
  input  logic                  flags_high,
  input  logic                  flag_low,
  input  logic                  flag_high,
  input  logic                  miso,
  output logic                  ss_n,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  spi_state_e            state_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic                  lsb_q;
  logic [DATA_WIDTH-1:0] tx_sreg_q;
  logic [DATA_WIDTH-1:0] rx_sreg_q;

  logic                  pre_stb;
  logic                  edge_stb;
  logic                  in_shift;
  logic                  accept;
  logic                  sample;
  logic                  shift_edge;
  logic                  last_edge;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_sample;

  // Strobe decode and the sampled-word view that includes a same-cycle pre strobe.
  always_comb begin
    pre_stb    = flags_low | flags_high;
    edge_stb   = flag_low | flag_high;
    in_shift   = (state_q == StShift);
    accept     = (state_q == StIdle) && tx_valid;
    sample     = in_shift && pre_stb;
    shift_edge = in_shift && edge_stb;
    last_edge  = shift_edge && (bit_cnt_q == LastCnt);
    rx_shift   = lsb_q ? {miso, rx_sreg_q[DATA_WIDTH-1:1]}
                       : {rx_sreg_q[DATA_WIDTH-2:0], miso};
    // Sample-then-shift ordering: the final word must include a coincident sample.
    rx_sample  = sample ? rx_shift : rx_sreg_q;
  end

  // Current transmit bit; idle low outside SHIFT.
  always_comb begin
    mosi = 1'b0;
    if (in_shift) begin
      mosi = lsb_q ? tx_sreg_q[0] : tx_sreg_q[DATA_WIDTH-1];
    end
  end

  // Transmit shift register: loaded at accept, advanced on every non-final edge.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_sreg_q <= '0;
    end else if (accept) begin
      tx_sreg_q <= tx_data;
    end else if (shift_edge && !last_edge) begin
      tx_sreg_q <= lsb_q ? {1'b0, tx_sreg_q[DATA_WIDTH-1:1]}
                         : {tx_sreg_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Receive shift register: cleared at accept, samples MISO on each pre strobe.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_sreg_q <= '0;
    end else if (accept) begin
      rx_sreg_q <= '0;
    end else if (sample) begin
      rx_sreg_q <= rx_shift;
    end
  end

  // Transfer FSM with registered handshake, select and result outputs.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      lsb_q     <= 1'b0;
      tx_ready  <= 1'b1;
      ss_n      <= 1'b1;
      busy      <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tx_valid) begin
            state_q   <= StShift;
            bit_cnt_q <= '0;
            lsb_q     <= lsbfe;
            tx_ready  <= 1'b0;
            ss_n      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        StShift: begin
          if (edge_stb) begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
            if (bit_cnt_q == LastCnt) begin
              state_q  <= StDone;
              ss_n     <= 1'b1;
              rx_valid <= 1'b1;
              rx_data  <= rx_sample;
            end
          end
        end
        StDone: begin
          state_q  <= StIdle;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          tx_ready <= 1'b1;
          ss_n     <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
